// File: rtl/sound_ch4_envelope_length.sv
// Channel-4 amplitude stage: gates the noise LFSR bit with the volume envelope
// and the length counter, and produces the registered sample for the mixer.
module sound_ch4_envelope_length #(
   parameter int VOL_WIDTH = 4,
   parameter int LEN_WIDTH = 6
) (
   input  logic                 iClock,
   input  logic                 iReset,
   input  logic                 iLengthTick,
   input  logic                 iEnvelopeTick,
   input  logic                 iLengthLoad,
   input  logic [LEN_WIDTH-1:0] iLengthData,
   input  logic [VOL_WIDTH-1:0] iInitialVolume,
   input  logic                 iEnvelopeUp,
   input  logic [2:0]           iEnvelopePeriod,
   input  logic                 iLengthEnable,
   input  logic                 iTrigger,
   input  logic                 iNoise,
   output logic [VOL_WIDTH-1:0] oSample,
   output logic [VOL_WIDTH-1:0] oVolume,
   output logic                 oActive
);

   typedef enum logic {IDLE, PLAYING} chanState_t;

   localparam logic [LEN_WIDTH:0]   FULL_LEN = {1'b1, {LEN_WIDTH{1'b0}}};
   localparam logic [VOL_WIDTH-1:0] MAX_VOL  = {VOL_WIDTH{1'b1}};

   chanState_t           state, stateNext;
   logic [LEN_WIDTH:0]   lengthCounter, lengthNext;
   logic [2:0]           envTimer, envTimerNext;
   logic [VOL_WIDTH-1:0] volumeNext;
   logic [VOL_WIDTH-1:0] sampleNext;

   logic                 dacOff;
   logic [LEN_WIDTH:0]   loadedLength;
   logic                 lengthExpires;

   // The length write is folded in ahead of the trigger so a trigger in the
   // same cycle sees the freshly loaded count.
   always_comb begin
      dacOff       = (iInitialVolume == '0) && !iEnvelopeUp;
      loadedLength = iLengthLoad ? (FULL_LEN - {1'b0, iLengthData}) : lengthCounter;
   end

   always_comb begin
      lengthNext    = loadedLength;
      lengthExpires = 1'b0;
      if (iTrigger) begin
         if (loadedLength == '0) lengthNext = FULL_LEN;
      end else if ((state == PLAYING) && iLengthTick && iLengthEnable &&
                   (loadedLength != '0)) begin
         lengthNext    = loadedLength - 1'b1;
         lengthExpires = (lengthNext == '0);
      end
   end

   // Envelope steps when the timer would hit zero, then reloads from the period.
   always_comb begin
      envTimerNext = envTimer;
      volumeNext   = oVolume;
      if (iTrigger) begin
         envTimerNext = iEnvelopePeriod;
         volumeNext   = iInitialVolume;
      end else if ((state == PLAYING) && iEnvelopeTick && (iEnvelopePeriod != 3'd0)) begin
         if (envTimer <= 3'd1) begin
            envTimerNext = iEnvelopePeriod;
            if (iEnvelopeUp && (oVolume != MAX_VOL))
               volumeNext = oVolume + 1'b1;
            else if (!iEnvelopeUp && (oVolume != '0))
               volumeNext = oVolume - 1'b1;
         end else begin
            envTimerNext = envTimer - 3'd1;
         end
      end
   end

   always_comb begin
      stateNext = state;
      if (iTrigger)
         stateNext = dacOff ? IDLE : PLAYING;
      else if ((state == PLAYING) && (dacOff || lengthExpires))
         stateNext = IDLE;
   end

   always_comb begin
      sampleNext = '0;
      if ((state == PLAYING) && iNoise) sampleNext = oVolume;
   end

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         state         <= IDLE;
         lengthCounter <= '0;
         envTimer      <= 3'd0;
         oVolume       <= '0;
         oSample       <= '0;
      end else begin
         state         <= stateNext;
         lengthCounter <= lengthNext;
         envTimer      <= envTimerNext;
         oVolume       <= volumeNext;
         oSample       <= sampleNext;
      end
   end

   assign oActive = (state == PLAYING);

endmodule

// File: tb/tb_sound_ch4_envelope_length.sv
// Directed bench for the channel-4 envelope/length stage; inputs change on the
// falling edge and outputs are checked on the falling edge.
module tb_sound_ch4_envelope_length;

   logic       iClock = 1'b0;
   logic       iReset;
   logic       iLengthTick, iEnvelopeTick, iLengthLoad, iTrigger;
   logic [5:0] iLengthData;
   logic [3:0] iInitialVolume;
   logic       iEnvelopeUp;
   logic [2:0] iEnvelopePeriod;
   logic       iLengthEnable;
   logic       iNoise;
   logic [3:0] oSample, oVolume;
   logic       oActive;

   int checks = 0;
   int errors = 0;

   sound_ch4_envelope_length dut (
      .iClock(iClock), .iReset(iReset),
      .iLengthTick(iLengthTick), .iEnvelopeTick(iEnvelopeTick),
      .iLengthLoad(iLengthLoad), .iLengthData(iLengthData),
      .iInitialVolume(iInitialVolume), .iEnvelopeUp(iEnvelopeUp),
      .iEnvelopePeriod(iEnvelopePeriod), .iLengthEnable(iLengthEnable),
      .iTrigger(iTrigger), .iNoise(iNoise),
      .oSample(oSample), .oVolume(oVolume), .oActive(oActive)
   );

   always #5 iClock = ~iClock;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Holds the given strobes high for one clock, returning at the next falling edge.
   task automatic applyStimulus(input logic trig, input logic lenTick,
                                input logic envTick, input logic lenLoad);
      iTrigger      = trig;
      iLengthTick   = lenTick;
      iEnvelopeTick = envTick;
      iLengthLoad   = lenLoad;
      @(negedge iClock);
      iTrigger      = 1'b0;
      iLengthTick   = 1'b0;
      iEnvelopeTick = 1'b0;
      iLengthLoad   = 1'b0;
   endtask

   task automatic setEnvelope(input logic [3:0] vol, input logic up, input logic [2:0] per);
      iInitialVolume  = vol;
      iEnvelopeUp     = up;
      iEnvelopePeriod = per;
   endtask

   initial begin
      iReset = 1'b1;
      iLengthTick = 0; iEnvelopeTick = 0; iLengthLoad = 0; iTrigger = 0;
      iLengthData = 6'd0; iLengthEnable = 0; iNoise = 0;
      setEnvelope(4'd0, 1'b0, 3'd0);
      repeat (2) @(negedge iClock);
      checkOutput("reset active", oActive, 0);
      checkOutput("reset volume", oVolume, 0);
      checkOutput("reset sample", oSample, 0);
      iReset = 1'b0;
      @(negedge iClock);

      // Reset in the middle of playback clears everything asynchronously
      setEnvelope(4'd9, 1'b0, 3'd0);
      iNoise = 1'b1;
      applyStimulus(1, 0, 0, 0);
      checkOutput("play9 active", oActive, 1);
      checkOutput("play9 volume", oVolume, 9);
      @(negedge iClock);
      checkOutput("play9 sample", oSample, 9);
      #2 iReset = 1'b1;
      #1;
      checkOutput("async rst active", oActive, 0);
      checkOutput("async rst volume", oVolume, 0);
      checkOutput("async rst sample", oSample, 0);
      @(negedge iClock);
      iReset = 1'b0;
      repeat (3) @(negedge iClock);
      checkOutput("post rst idle", oActive, 0);
      checkOutput("post rst sample", oSample, 0);

      // Volume 15 decaying every tick
      setEnvelope(4'd15, 1'b0, 3'd1);
      applyStimulus(1, 0, 0, 0);
      @(negedge iClock);
      checkOutput("down start sample", oSample, 15);
      for (int i = 1; i <= 15; i++) begin
         applyStimulus(0, 0, 1, 0);
         if (i == 5) checkOutput("down after 5", oVolume, 10);
      end
      checkOutput("down after 15", oVolume, 0);
      @(negedge iClock);
      checkOutput("down sample 0", oSample, 0);
      applyStimulus(0, 0, 1, 0);
      checkOutput("down tick16 vol", oVolume, 0);
      checkOutput("down tick16 active", oActive, 1);

      // Volume 0 rising every second tick
      setEnvelope(4'd0, 1'b1, 3'd2);
      applyStimulus(1, 0, 0, 0);
      checkOutput("up start active", oActive, 1);
      applyStimulus(0, 0, 1, 0);
      checkOutput("up after 1", oVolume, 0);
      applyStimulus(0, 0, 1, 0);
      checkOutput("up after 2", oVolume, 1);
      for (int i = 3; i <= 30; i++) begin
         applyStimulus(0, 0, 1, 0);
         if (i == 29) checkOutput("up after 29", oVolume, 14);
      end
      checkOutput("up after 30", oVolume, 15);
      repeat (4) applyStimulus(0, 0, 1, 0);
      checkOutput("up saturated", oVolume, 15);

      // Trigger in the same cycle as an envelope tick restores the initial volume
      setEnvelope(4'd12, 1'b0, 3'd1);
      applyStimulus(1, 0, 1, 0);
      checkOutput("trig+env volume", oVolume, 12);

      // Length 60 -> four ticks of playback
      setEnvelope(4'd8, 1'b0, 3'd0);
      iLengthData = 6'd60;
      applyStimulus(0, 0, 0, 1);
      iLengthEnable = 1'b1;
      applyStimulus(1, 0, 0, 0);
      repeat (3) applyStimulus(0, 1, 0, 0);
      checkOutput("len60 after 3", oActive, 1);
      applyStimulus(0, 1, 0, 0);
      checkOutput("len60 after 4", oActive, 0);
      checkOutput("len60 last sample", oSample, 8);
      @(negedge iClock);
      checkOutput("len60 sample idle", oSample, 0);

      // Expired counter reloads to 64 on trigger; simultaneous tick is ignored
      applyStimulus(1, 1, 0, 0);
      checkOutput("len64 active", oActive, 1);
      repeat (63) applyStimulus(0, 1, 0, 0);
      checkOutput("len64 after 63", oActive, 1);
      applyStimulus(0, 1, 0, 0);
      checkOutput("len64 after 64", oActive, 0);

      // Length write and trigger together: trigger uses the new length of 2
      iLengthData = 6'd62;
      applyStimulus(1, 0, 0, 1);
      applyStimulus(0, 1, 0, 0);
      checkOutput("load+trig after 1", oActive, 1);
      applyStimulus(0, 1, 0, 0);
      checkOutput("load+trig after 2", oActive, 0);
      iLengthEnable = 1'b0;

      // Length ticks are ignored while length is disabled
      applyStimulus(1, 0, 0, 0);
      repeat (5) applyStimulus(0, 1, 0, 0);
      checkOutput("len disabled", oActive, 1);

      // DAC switched off during playback
      setEnvelope(4'd0, 1'b0, 3'd0);
      @(negedge iClock);
      checkOutput("dac off mid-play", oActive, 0);

      // Trigger with DAC off never starts the channel
      applyStimulus(1, 0, 0, 0);
      checkOutput("dac off trig", oActive, 0);
      for (int i = 0; i < 4; i++) begin
         iNoise = i[0];
         @(negedge iClock);
         checkOutput("dac off sample", oSample, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
